// File: rtl/bsu_phase_sequencer_if.sv
// Shared signal bundle for the beam-steering phase sequencer.
//   master : sequencer side (drives command handshake response, LUT address/enable,
//            serial phase-shifter interface and status)
//   slave  : environment side (host command source plus the LUT bank on the shared bus)
// Signals:
//   cmd_valid/cmd_ready/cmd_teta/cmd_piv  beam command handshake
//   lut_teta/lut_piv/lut_en/lut_phase     LUT address, per-LUT enable, shared phase bus
//   sclk/sdo/sle                          serial clock, data and latch strobe
//   busy/done                             sequence status
interface bsu_phase_sequencer_if #(
    parameter int NUM_ELEM = 8,
    parameter int PHASE_W  = 5
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_teta;
    logic [1:0]          cmd_piv;
    logic [3:0]          lut_teta;
    logic [1:0]          lut_piv;
    logic [NUM_ELEM-1:0] lut_en;
    logic [PHASE_W-1:0]  lut_phase;
    logic                sclk;
    logic                sdo;
    logic                sle;
    logic                busy;
    logic                done;

    modport master (
        input  cmd_valid, cmd_teta, cmd_piv, lut_phase,
        output cmd_ready, lut_teta, lut_piv, lut_en, sclk, sdo, sle, busy, done
    );

    modport slave (
        output cmd_valid, cmd_teta, cmd_piv, lut_phase,
        input  cmd_ready, lut_teta, lut_piv, lut_en, sclk, sdo, sle, busy, done
    );
endinterface

// File: rtl/bsu_phase_sequencer.sv
// Beam-steering sequencer. Accepts a (teta, piv) command, presents it to all
// element LUTs, enables the LUTs one at a time on the shared phase bus
// (break-before-make), captures every phase, shifts them out serially
// (last element first, MSB first) and pulses the latch strobe.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset, aborts any sequence in flight
//   bus    bsu_phase_sequencer_if.master (command, LUT, serial and status signals)
//
// Build option:
//   BSU_PARITY_EN  when defined, every shifted word carries a trailing odd-parity
//                  bit (XNOR-reduce of the phase); ports are unchanged.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | cmd_ready high, waiting for a command
// S_SEL   | lut_en[k] high, LUT output settling (SETTLE_CYC cycles)
// S_CAP   | lut_en[k] still high, bus captured into phase_buf[k]
// S_GAP   | all enables low for one cycle before the next element
// S_SHIFT | serial shift, sclk low then high CLK_DIV cycles per bit
// S_LATCH | sle high for 2*CLK_DIV cycles
// S_DONE  | one-cycle done pulse, busy low
module bsu_phase_sequencer #(
    parameter int NUM_ELEM   = 8,
    parameter int PHASE_W    = 5,
    parameter int SETTLE_CYC = 2,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bsu_phase_sequencer_if.master bus
);

`ifdef BSU_PARITY_EN
    localparam int WORD_W = PHASE_W + 1;
`else
    localparam int WORD_W = PHASE_W;
`endif
    localparam int NBITS   = NUM_ELEM * WORD_W;
    localparam int KW      = $clog2(NUM_ELEM);
    localparam int BW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int TMR_MAX = (SETTLE_CYC > 2 * CLK_DIV) ? SETTLE_CYC : 2 * CLK_DIV;
    localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(NUM_ELEM - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(NBITS - 1);
    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_LATCH  = TW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CAP,
        S_GAP,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                hi_q, hi_d;
    logic [3:0]          teta_q, teta_d;
    logic [1:0]          piv_q, piv_d;

    logic [NUM_ELEM-1:0] lut_en_q, lut_en_d;
    logic                sclk_q, sclk_d;
    logic                sdo_q, sdo_d;
    logic                sle_q, sle_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

    logic [PHASE_W-1:0]  phase_buf [NUM_ELEM];
    logic [NBITS-1:0]    stream;

    // Element NUM_ELEM-1 sits in the top word so that counting bit_q down
    // from NBITS-1 yields last-element-first, MSB-first order.
    always_comb begin
        stream = '0;
        for (int e = 0; e < NUM_ELEM; e++) begin
`ifdef BSU_PARITY_EN
            stream[e*WORD_W +: WORD_W] = {phase_buf[e], ~^phase_buf[e]};
`else
            stream[e*WORD_W +: WORD_W] = phase_buf[e];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        teta_d  = teta_q;
        piv_d   = piv_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    teta_d  = bus.cmd_teta;
                    piv_d   = bus.cmd_piv;
                    k_d     = '0;
                    tmr_d   = T_SETTLE;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (tmr_q == '0) begin
                    state_d = S_CAP;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_CAP: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (k_q == K_LAST) begin
                    bit_d   = B_LAST;
                    hi_d    = 1'b0;
                    tmr_d   = T_HALF;
                    state_d = S_SHIFT;
                end else begin
                    k_d     = k_q + KW'(1);
                    tmr_d   = T_SETTLE;
                    state_d = S_SEL;
                end
            end
            S_SHIFT: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (!hi_q) begin
                    hi_d  = 1'b1;
                    tmr_d = T_HALF;
                end else if (bit_q == '0) begin
                    hi_d    = 1'b0;
                    tmr_d   = T_LATCH;
                    state_d = S_LATCH;
                end else begin
                    bit_d = bit_q - BW'(1);
                    hi_d  = 1'b0;
                    tmr_d = T_HALF;
                end
            end
            S_LATCH: begin
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so every pin comes
    // straight off a flop: no decode glitches on lut_en or sclk.
    always_comb begin
        lut_en_d = '0;
        if (state_d == S_SEL || state_d == S_CAP) begin
            lut_en_d[k_d] = 1'b1;
        end
        sclk_d  = (state_d == S_SHIFT) && hi_d;
        sdo_d   = (state_d == S_SHIFT) ? stream[bit_d] : 1'b0;
        sle_d   = (state_d == S_LATCH);
        busy_d  = !(state_d == S_IDLE || state_d == S_DONE);
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            tmr_q    <= '0;
            bit_q    <= '0;
            hi_q     <= 1'b0;
            teta_q   <= '0;
            piv_q    <= '0;
            lut_en_q <= '0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
            sle_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            hi_q     <= hi_d;
            teta_q   <= teta_d;
            piv_q    <= piv_d;
            lut_en_q <= lut_en_d;
            sclk_q   <= sclk_d;
            sdo_q    <= sdo_d;
            sle_q    <= sle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // lut_en_q is high throughout S_CAP, so the bus is only sampled while driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_ELEM; e++) begin
                phase_buf[e] <= '0;
            end
        end else if (state_q == S_CAP) begin
            phase_buf[k_q] <= bus.lut_phase;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.lut_teta  = teta_q;
    assign bus.lut_piv   = piv_q;
    assign bus.lut_en    = lut_en_q;
    assign bus.sclk      = sclk_q;
    assign bus.sdo       = sdo_q;
    assign bus.sle       = sle_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_bsu_phase_sequencer.sv
`timescale 1ns/1ps
module tb_bsu_phase_sequencer;
    localparam int N  = 4;
    localparam int PW = 5;
    localparam int S  = 2;
    localparam int D  = 1;
`ifdef BSU_PARITY_EN
    localparam int WW = PW + 1;
    localparam logic [N*WW-1:0] EXP_STREAM = 24'b111110_101010_010101_000010;
    localparam int EXP_LAT = 67;
`else
    localparam int WW = PW;
    localparam logic [N*WW-1:0] EXP_STREAM = 20'b11111_10101_01010_00001;
    localparam int EXP_LAT = 59;
`endif
    localparam int NB      = N * WW;
    localparam int ECYC    = S + 2;
    localparam int CAP_END = N * ECYC;
    localparam int SH_END  = CAP_END + NB * 2 * D;
    localparam int LAT_END = SH_END + 2 * D;
    localparam int TOTAL   = LAT_END + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsu_phase_sequencer_if #(.NUM_ELEM(N), .PHASE_W(PW)) bus ();

    bsu_phase_sequencer #(
        .NUM_ELEM(N), .PHASE_W(PW), .SETTLE_CYC(S), .CLK_DIV(D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // LUT bank: each element's phase depends on the presented address;
    // with no single LUT enabled the bus carries junk.
    logic [PW-1:0] rom [16][4][N];
    logic [PW-1:0] junk;
    always @(negedge clk) junk <= PW'($urandom);
    always_comb begin
        bus.lut_phase = junk;
        if ($countones(bus.lut_en) == 1) begin
            for (int e = 0; e < N; e++) begin
                if (bus.lut_en[e]) bus.lut_phase = rom[bus.lut_teta][bus.lut_piv][e];
            end
        end
    end

    // Reference model: cycle offset since accept (0 = idle) plus the command.
    int         off;
    logic [3:0] m_teta;
    logic [1:0] m_piv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off    <= 0;
            m_teta <= '0;
            m_piv  <= '0;
        end else if (off == 0) begin
            if (bus.cmd_valid) begin
                off    <= 1;
                m_teta <= bus.cmd_teta;
                m_piv  <= bus.cmd_piv;
            end
        end else if (off == TOTAL) begin
            off <= 0;
        end else begin
            off <= off + 1;
        end
    end

    // p-th transmitted bit: words from element N-1 down, MSB first, parity last.
    function automatic logic exp_bit(input int p);
        int            e;
        int            q;
        logic [PW-1:0] w;
        e = N - 1 - p / WW;
        q = p % WW;
        w = rom[m_teta][m_piv][e];
        if (q < PW) return w[PW-1-q];
        return ~^w;
    endfunction

    logic [N-1:0] prev_en = '0;
    always @(negedge clk) begin
        logic [N-1:0] e_en;
        logic         e_sclk, e_sdo, e_sle;
        int           j;
        e_en   = '0;
        e_sclk = 1'b0;
        e_sdo  = 1'b0;
        e_sle  = 1'b0;
        if (off >= 1 && off <= CAP_END) begin
            j = off - 1;
            if (j % ECYC <= S) e_en[j / ECYC] = 1'b1;
        end else if (off > CAP_END && off <= SH_END) begin
            j = off - CAP_END - 1;
            e_sclk = ((j % (2 * D)) >= D);
            e_sdo  = exp_bit(j / (2 * D));
        end else if (off > SH_END && off <= LAT_END) begin
            e_sle = 1'b1;
        end
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(off == 0));
        chk("busy", 32'(bus.busy), 32'(off != 0 && off != TOTAL));
        chk("done", 32'(bus.done), 32'(off == TOTAL));
        chk("lut_en", 32'(bus.lut_en), 32'(e_en));
        chk("sclk", 32'(bus.sclk), 32'(e_sclk));
        chk("sdo", 32'(bus.sdo), 32'(e_sdo));
        chk("sle", 32'(bus.sle), 32'(e_sle));
        chk("lut_teta", 32'(bus.lut_teta), 32'(m_teta));
        chk("lut_piv", 32'(bus.lut_piv), 32'(m_piv));
        chk("onehot", 32'($countones(bus.lut_en) <= 1), 32'(1));
        chk("break_before_make",
            32'(prev_en == '0 || bus.lut_en == '0 || prev_en == bus.lut_en), 32'(1));
        prev_en = bus.lut_en;
    end

    // Bits shifted on each rising sclk, sle-high cycles and done pulses.
    logic [NB-1:0] got_bits;
    logic          prev_sclk = 1'b0;
    int            sle_cyc   = 0;
    int            done_cnt  = 0;
    always @(negedge clk) begin
        if (bus.sclk && !prev_sclk) got_bits <= {got_bits[NB-2:0], bus.sdo};
        prev_sclk <= bus.sclk;
        if (bus.sle) sle_cyc <= sle_cyc + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(bus.cmd_ready), 32'(1));
    endtask

    // Called at a negedge with the DUT idle; returns cycles from accept to done.
    task automatic run_cmd(input logic [3:0] t, input logic [1:0] p, output int lat);
        bus.cmd_valid = 1'b1;
        bus.cmd_teta  = t;
        bus.cmd_piv   = p;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 4 * TOTAL) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'(1));
        chk({tag, "_lut_en"}, 32'(bus.lut_en), 32'(0));
        chk({tag, "_lut_teta"}, 32'(bus.lut_teta), 32'(0));
        chk({tag, "_lut_piv"}, 32'(bus.lut_piv), 32'(0));
        chk({tag, "_sclk"}, 32'(bus.sclk), 32'(0));
        chk({tag, "_sdo"}, 32'(bus.sdo), 32'(0));
        chk({tag, "_sle"}, 32'(bus.sle), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_done"}, 32'(bus.done), 32'(0));
    endtask

    initial begin
        int lat;
        int sle0;
        int done0;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_teta  = '0;
        bus.cmd_piv   = '0;
        for (int t = 0; t < 16; t++)
            for (int p = 0; p < 4; p++)
                for (int e = 0; e < N; e++)
                    rom[t][p][e] = PW'($urandom);
        rom[5][2][0] = 5'h01;
        rom[5][2][1] = 5'h0A;
        rom[5][2][2] = 5'h15;
        rom[5][2][3] = 5'h1F;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Reference command with hand-computed stream and latency.
        sle0 = sle_cyc;
        run_cmd(4'h5, 2'b10, lat);
        chk("t2_latency", 32'(lat), 32'(EXP_LAT));
        chk("t2_stream", 32'(got_bits), 32'(EXP_STREAM));
        chk("t2_sle_cycles", 32'(sle_cyc - sle0), 32'(2));
        chk("t2_lut_teta", 32'(bus.lut_teta), 32'(5));
        chk("t2_lut_piv", 32'(bus.lut_piv), 32'(2));
        @(negedge clk);

        // Async reset mid-cycle while an element is enabled.
        bus.cmd_valid = 1'b1;
        bus.cmd_teta  = 4'hA;
        bus.cmd_piv   = 2'b01;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during bit 7 of the shift: no latch pulse, then a clean run.
        bus.cmd_valid = 1'b1;
        bus.cmd_teta  = 4'(($urandom));
        bus.cmd_piv   = 2'(($urandom));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (off != CAP_END + 7 * 2 * D + 1 && n < 2 * TOTAL) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_bit7", 32'(bus.sclk == 1'b0 && bus.busy), 32'(1));
        sle0 = sle_cyc;
        rst_n = 1'b0;
        #1 check_reset_outputs("shift_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (TOTAL) @(negedge clk);
        chk("t5_no_sle", 32'(sle_cyc - sle0), 32'(0));
        run_cmd(4'(($urandom)), 2'(($urandom)), lat);
        chk("t5_latency", 32'(lat), 32'(EXP_LAT));
        @(negedge clk);

        // cmd_valid held through two sequences: exactly two completions.
        done0 = done_cnt;
        bus.cmd_valid = 1'b1;
        repeat (2 * (TOTAL + 1)) begin
            bus.cmd_teta = 4'(($urandom));
            bus.cmd_piv  = 2'(($urandom));
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_done_count", 32'(done_cnt - done0), 32'(2));
        wait_idle(2 * TOTAL);

        // Random command traffic, including valid pulses while busy.
        for (int it = 0; it < 15; it++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            repeat ($urandom_range(TOTAL, 3 * TOTAL)) begin
                bus.cmd_valid = ($urandom_range(0, 3) == 0);
                bus.cmd_teta  = 4'(($urandom));
                bus.cmd_piv   = 2'(($urandom));
                @(negedge clk);
            end
            bus.cmd_valid = 1'b0;
            wait_idle(2 * TOTAL);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
